rr_mux4_arbiter: RTL and testbench
==================================

Name: rr_mux4_arbiter

Overview:
- Round-robin arbiter sharing one W-bit 4:1 mux datapath among four requesters.
- Registers the grant and drives the mux select.
- Routes the granted requester's data to a single valid/ready output port.
- Sits between four producer lanes and one downstream consumer in the lab datapath.

Parameters:
- W, 8, data width of each requester lane and of the output.
- MAX_BEATS, 4, transfers one requester may complete before forced rotation. Used only with the optional feature. Legal range 1..255.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req  in  4  request per lane. A lane holds req high while it has data.
- din  in  4*W  lane data, flattened: lane i occupies bits [i*W+W-1 : i*W].
- out_ready  in  1  downstream accepts data this cycle.
- grant  out  4  one-hot registered grant, 0 when idle.
- sel  out  2  registered mux select = index of the granted lane.
- dout  out  W  din of lane sel while granted, else 0.
- out_valid  out  1  grant active and req[sel]=1.
- xfer  out  1  out_valid & out_ready; one pulse per beat accepted.

Behaviour:
- Reset, synchronous, active-high, sampled on the rising edge:
  - state=IDLE, grant=0, sel=0, ptr=0, beat_cnt=0.
  - Outputs therefore read out_valid=0, dout=0, xfer=0.
  - Reset mid-transfer drops the grant at that edge with no beat completed. Reset overrides all other inputs.
- State IDLE:
  - grant=0.
  - If any req bit is high at an edge, choose the first lane with req=1 searching ptr, ptr+1, ... mod 4. Go to GRANT, grant=onehot(choice), sel=choice.
  - Grant latency is 1 cycle: req high at edge k, grant visible after edge k.
- State GRANT:
  - dout = din[sel] combinationally.
  - out_valid = req[sel].
  - xfer = out_valid & out_ready.
- Release condition, evaluated at each edge in GRANT: req[sel]=0, or forced rotation (optional feature).
  - On release: ptr <= sel+1 mod 4, then arbitrate among lanes other than sel starting from sel+1.
  - If a winner exists, go straight to GRANT with the new lane, with no idle bubble.
  - If no winner, go to IDLE.
  - If req[sel] drops and the same lane re-raises req later, it competes normally from ptr.
- No release: grant, sel and ptr hold.
- Simultaneous requests are resolved purely by rotating priority. Lane 3 wraps to lane 0.
- grant is always one-hot or zero.
- sel never changes while state stays GRANT on the same lane.

Optional Feature:
- Macro: RR_MUX4_ARBITER_MAXBEATS_EN.
- With the macro defined:
  - 8-bit beat_cnt increments on each xfer and resets to 0 on every grant change.
  - When an xfer brings beat_cnt to MAX_BEATS and any other lane has req=1, the current lane is force-released at that edge.
  - If no other lane requests, beat_cnt clears to 0 and the grant is kept.
- Without the macro: no counter; a lane keeps the grant until it drops req.

Test Plan:
- Reset and idle: assert rst for 2 cycles with req=4'b1111, then release.
  - grant=0, out_valid=0, dout=0 while rst=1.
  - First edge after release gives grant=4'b0001, sel=0.
- Single lane: req=4'b0100, din lane2=8'hA5, out_ready=1.
  - One cycle later: grant=4'b0100, sel=2, dout=8'hA5, xfer=1 every cycle.
  - Drop req: next edge grant=0.
- Round-robin: all four lanes request continuously and each drops req after 2 beats, then re-raises it.
  - Grant order is 0,1,2,3,0.
  - No idle cycle between grants.
  - Exactly 2 xfer pulses per grant.
- Backpressure: lane 1 granted, out_ready=0 for 3 cycles.
  - out_valid=1, xfer=0, dout stable, grant unchanged.
  - out_ready=1 gives xfer=1.
- Forced rotation (macro on, MAX_BEATS=4): lanes 0 and 3 hold req high, out_ready=1.
  - Lane 0 is granted for 4 xfers, then lane 3 for 4, alternating.
  - With only lane 0 requesting, lane 0 keeps the grant indefinitely.
- Reset mid-operation: assert rst while lane 2 is granted.
  - At that edge grant=0, ptr=0.
  - After release with req=4'b0110, lane 1 is granted first.

Source files
------------

// File: rtl/rr_mux4_arbiter.sv
// Round-robin 4:1 arbiter and W-bit mux. The grant is registered and drives a single valid/ready output.
// Define RR_MUX4_ARBITER_MAXBEATS_EN to force rotation after MAX_BEATS accepted beats.
module rr_mux4_arbiter #(
    parameter int W         = 8,
    parameter int MAX_BEATS = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [3:0]     req,
    input  logic [4*W-1:0] din,
    input  logic           out_ready,
    output logic [3:0]     grant,
    output logic [1:0]     sel,
    output logic [W-1:0]   dout,
    output logic           out_valid,
    output logic           xfer
);

    typedef enum logic {IDLE, GRANT} arbState;

    arbState    state, stateNext;
    logic [3:0] grantNext;
    logic [1:0] selNext;
    logic [1:0] ptr, ptrNext;
    logic [3:0] otherReq;
    logic       releaseLane;
    logic [2:0] pick;
`ifdef RR_MUX4_ARBITER_MAXBEATS_EN
    logic [7:0] beatCnt, beatCntNext;
`endif

    if (MAX_BEATS < 1 || MAX_BEATS > 255) begin : gBadMaxBeats
        $error("rr_mux4_arbiter: MAX_BEATS must be in 1..255");
    end

    // Returns {found, lane}: first requesting lane searching start, start+1, ... mod 4.
    function automatic logic [2:0] pickLane(input logic [3:0] reqs, input logic [1:0] start);
        logic [2:0] result;
        logic [1:0] idx;
        result = 3'b000;
        for (int k = 0; k < 4; k++) begin
            idx = start + 2'(k);
            if (!result[2] && reqs[idx]) result = {1'b1, idx};
        end
        return result;
    endfunction

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            grant <= '0;
            sel   <= '0;
            ptr   <= '0;
`ifdef RR_MUX4_ARBITER_MAXBEATS_EN
            beatCnt <= '0;
`endif
        end else begin
            state <= stateNext;
            grant <= grantNext;
            sel   <= selNext;
            ptr   <= ptrNext;
`ifdef RR_MUX4_ARBITER_MAXBEATS_EN
            beatCnt <= beatCntNext;
`endif
        end
    end

    always_comb begin
        stateNext   = state;
        grantNext   = grant;
        selNext     = sel;
        ptrNext     = ptr;
        releaseLane = 1'b0;
        pick        = '0;
        otherReq    = req & ~(4'b0001 << sel);
`ifdef RR_MUX4_ARBITER_MAXBEATS_EN
        beatCntNext = beatCnt;
`endif
        case (state)
            IDLE: begin
                pick = pickLane(req, ptr);
                if (pick[2]) begin
                    stateNext = GRANT;
                    grantNext = 4'b0001 << pick[1:0];
                    selNext   = pick[1:0];
`ifdef RR_MUX4_ARBITER_MAXBEATS_EN
                    beatCntNext = '0;
`endif
                end
            end
            GRANT: begin
`ifdef RR_MUX4_ARBITER_MAXBEATS_EN
                if (xfer) begin
                    if (beatCnt + 8'd1 == 8'(MAX_BEATS)) begin
                        // With nobody waiting, restart the quota instead of rotating.
                        if (|otherReq) releaseLane = 1'b1;
                        else           beatCntNext = '0;
                    end else begin
                        beatCntNext = beatCnt + 8'd1;
                    end
                end
`endif
                if (!req[sel]) releaseLane = 1'b1;
                if (releaseLane) begin
                    ptrNext = sel + 2'd1;
                    pick    = pickLane(otherReq, sel + 2'd1);
`ifdef RR_MUX4_ARBITER_MAXBEATS_EN
                    beatCntNext = '0;
`endif
                    if (pick[2]) begin
                        grantNext = 4'b0001 << pick[1:0];
                        selNext   = pick[1:0];
                    end else begin
                        stateNext = IDLE;
                        grantNext = '0;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        dout      = '0;
        out_valid = 1'b0;
        xfer      = 1'b0;
        if (state == GRANT) begin
            dout      = din[int'(sel)*W +: W];
            out_valid = req[sel];
            xfer      = out_valid & out_ready;
        end
    end

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Self-checking bench for rr_mux4_arbiter: directed scenarios plus random traffic against a lane-level model.
// Define RR_MUX4_ARBITER_MAXBEATS_EN to build and check the forced-rotation feature.
module tb_rr_mux4_arbiter;

    localparam int W         = 8;
    localparam int MAX_BEATS = 4;
    localparam int OW        = W + 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [3:0]     req;
    logic [4*W-1:0] din;
    logic           out_ready;
    logic [3:0]     grant;
    logic [1:0]     sel;
    logic [W-1:0]   dout;
    logic           out_valid;
    logic           xfer;

    int vectors     = 0;
    int miscompares = 0;

    // Model state: who holds the grant, where the search starts next, beats in this tenure.
    bit mGranted  = 0;
    bit mSelKnown = 1;
    int mLane     = 0;
    int mPtr      = 0;
    int mBeats    = 0;
    int mXfers    = 0;

    logic [OW-1:0] obs, exp;

    rr_mux4_arbiter #(.W(W), .MAX_BEATS(MAX_BEATS)) dut (
        .clk(clk), .rst(rst), .req(req), .din(din), .out_ready(out_ready),
        .grant(grant), .sel(sel), .dout(dout), .out_valid(out_valid), .xfer(xfer)
    );

    always #5 clk = ~clk;

    function automatic int firstFrom(input logic [3:0] r, input int s);
        for (int k = 0; k < 4; k++)
            if (r[(s + k) % 4]) return (s + k) % 4;
        return -1;
    endfunction

    function automatic void modelEdge();
        int         w;
        logic [3:0] others;
        bit         rel;
        bit         accepted;
        if (rst) begin
            mGranted = 0; mSelKnown = 1; mLane = 0; mPtr = 0; mBeats = 0; mXfers = 0;
            return;
        end
        if (!mGranted) begin
            w = firstFrom(req, mPtr);
            if (w >= 0) begin
                mGranted = 1; mSelKnown = 1; mLane = w; mBeats = 0; mXfers = 0;
            end
            return;
        end
        accepted     = req[mLane] && out_ready;
        rel          = !req[mLane];
        others       = req;
        others[mLane] = 1'b0;
        if (accepted) mXfers++;
`ifdef RR_MUX4_ARBITER_MAXBEATS_EN
        if (accepted) begin
            mBeats++;
            if (mBeats == MAX_BEATS) begin
                if (others != 0) rel = 1;
                else             mBeats = 0;
            end
        end
`endif
        if (rel) begin
            mPtr   = (mLane + 1) % 4;
            mBeats = 0;
            w      = firstFrom(others, mPtr);
            if (w >= 0) begin
                mLane = w; mXfers = 0;
            end else begin
                mGranted = 0; mSelKnown = 0;
            end
        end
    endfunction

    // Expected {grant, sel, dout, out_valid, xfer} for the current inputs.
    function automatic logic [OW-1:0] modelOut();
        logic [3:0]   g;
        logic [1:0]   s;
        logic [W-1:0] d;
        logic         v;
        g = mGranted ? 4'(1 << mLane) : 4'b0000;
        s = mSelKnown ? 2'(mLane) : 2'b00;
        d = mGranted ? din[mLane*W +: W] : '0;
        v = mGranted && req[mLane];
        return {g, s, d, v, v && out_ready};
    endfunction

    function automatic logic [OW-1:0] observed();
        return {grant, (mSelKnown ? sel : 2'b00), dout, out_valid, xfer};
    endfunction

    task automatic tick();
        @(posedge clk);
        modelEdge();
        @(negedge clk);
    endtask

    task automatic randDin();
        for (int i = 0; i < 4; i++) din[i*W +: W] = W'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'b1111; out_ready = 1'b1; randDin();
        tick();
        for (int c = 0; c < 2; c++) begin
            #1 obs = observed(); exp = modelOut(); vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL reset_hold c=%0d: observed %h required %h", c, obs, exp);
            end
            tick();
        end
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1 obs = observed(); exp = modelOut(); vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL reset_release c=%0d: observed %h required %h", c, obs, exp);
            end
            if (c == 1) begin
                vectors++;
                if (grant !== 4'b0001 || sel !== 2'd0) begin
                    miscompares++;
                    $display("FAIL reset_first_grant: observed grant=%b sel=%0d required 0001/0", grant, sel);
                end
            end
            tick();
        end
    endtask

    task automatic test_single_lane();
        req = 4'b0100; out_ready = 1'b1; randDin(); din[2*W +: W] = 8'hA5;
        for (int c = 0; c < 8; c++) begin
            if (c == 5) req = 4'b0000;
            #1 obs = observed(); exp = modelOut(); vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL single_lane c=%0d: observed %h required %h", c, obs, exp);
            end
            tick();
        end
    endtask

    task automatic test_round_robin();
        int lanes[$];
        int lastLane;
        int xferCount;
        int lane;
        int order[5];
        order = '{0, 1, 2, 3, 0};
        rst = 1'b1; req = 4'b0000; tick(); rst = 1'b0;
        lastLane = -1; xferCount = 0;
        for (int c = 0; c < 24; c++) begin
            for (int i = 0; i < 4; i++) req[i] = !(mGranted && mLane == i && mXfers == 2);
            out_ready = 1'b1; randDin();
            #1 obs = observed(); exp = modelOut(); vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL round_robin c=%0d: observed %h required %h", c, obs, exp);
            end
            if (lastLane >= 0) begin
                vectors++;
                if (grant === 4'b0000) begin
                    miscompares++;
                    $display("FAIL rr_bubble c=%0d: observed grant=0 required a lane", c);
                end
            end
            if (grant !== 4'b0000) begin
                lane = int'(sel);
                if (lane != lastLane) begin
                    if (lastLane >= 0) begin
                        vectors++;
                        if (xferCount != 2) begin
                            miscompares++;
                            $display("FAIL rr_beats lane=%0d: observed %0d xfers required 2", lastLane, xferCount);
                        end
                    end
                    lanes.push_back(lane);
                    xferCount = 0;
                    lastLane  = lane;
                end
                if (xfer === 1'b1) xferCount++;
            end
            tick();
        end
        vectors++;
        if (lanes.size() < 5) begin
            miscompares++;
            $display("FAIL rr_order: observed %0d grants required at least 5", lanes.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                vectors++;
                if (lanes[k] != order[k]) begin
                    miscompares++;
                    $display("FAIL rr_order k=%0d: observed lane %0d required %0d", k, lanes[k], order[k]);
                end
            end
        end
        req = 4'b0000; tick(); tick();
    endtask

    task automatic test_backpressure();
        req = 4'b0010; randDin(); out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            out_ready = (c >= 1 && c <= 3) ? 1'b0 : 1'b1;
            if (c == 6) req = 4'b0000;
            #1 obs = observed(); exp = modelOut(); vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL backpressure c=%0d: observed %h required %h", c, obs, exp);
            end
            tick();
        end
    endtask

`ifdef RR_MUX4_ARBITER_MAXBEATS_EN
    task automatic test_forced_rotation();
        rst = 1'b1; req = 4'b0000; tick(); rst = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 34; c++) begin
            req = (c < 20) ? 4'b1001 : 4'b0001;
            randDin();
            #1 obs = observed(); exp = modelOut(); vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL forced_rotation c=%0d: observed %h required %h", c, obs, exp);
            end
            tick();
        end
        req = 4'b0000; tick(); tick();
    endtask
`endif

    task automatic test_reset_mid();
        req = 4'b0100; out_ready = 1'b1; randDin();
        for (int c = 0; c < 7; c++) begin
            rst = (c == 3);
            if (c >= 4) req = 4'b0110;
            #1 obs = observed(); exp = modelOut(); vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL reset_mid c=%0d: observed %h required %h", c, obs, exp);
            end
            if (c == 4) begin
                vectors++;
                if (grant !== 4'b0000) begin
                    miscompares++;
                    $display("FAIL reset_mid_drop: observed grant=%b required 0000", grant);
                end
            end
            if (c == 5) begin
                vectors++;
                if (grant !== 4'b0010) begin
                    miscompares++;
                    $display("FAIL reset_mid_first: observed grant=%b required 0010", grant);
                end
            end
            tick();
        end
        rst = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst       = ($urandom_range(0, 39) == 0);
            req       = 4'($urandom);
            out_ready = 1'($urandom);
            randDin();
            #1 obs = observed(); exp = modelOut(); vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL random c=%0d: observed %h required %h", c, obs, exp);
            end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = 4'b0000; din = '0; out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_lane();
        test_round_robin();
        test_backpressure();
`ifdef RR_MUX4_ARBITER_MAXBEATS_EN
        test_forced_rotation();
`endif
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
